gshare_predictor: RTL and testbench
===================================

// Module: gshare_predictor
// PURPOSE
//  Gshare direction predictor; downstream consumer of the EX-stage branch comparator's br_en.
//  Fetch side: looks up a 2-bit counter from PC^GHR and returns pred_taken plus the index used.
//  EX side: pipeline carries that index and prediction to EX. When the branch resolves (br_en),
//  the block trains the counter, shifts the GHR and raises a registered mispredict flag that drives flush.
// PARAMETERS
//  IDX_BITS  6     log2(entries) of the pattern history table (PHT)
//  GHR_BITS  6     global history length; legal range 1..IDX_BITS
//  CTR_INIT  2'b01 counter value loaded at reset (weakly not-taken)
// PORTS
//  clk            in   1         clock; all state updates on posedge
//  rst            in   1         synchronous, active-high reset
//  pred_valid     in   1         fetch requests a prediction this cycle
//  pred_pc        in   32        fetch PC (rv32i_word)
//  pred_taken     out  1         predicted direction (combinational)
//  pred_idx       out  IDX_BITS  PHT index used; carried down the pipe to upd_idx
//  upd_valid      in   1         one branch resolved in EX this cycle (single-cycle pulse per branch)
//  upd_idx        in   IDX_BITS  pred_idx captured at fetch for this branch
//  upd_br_en      in   1         actual outcome (br_en from comparator)
//  upd_pred_taken in   1         pred_taken captured at fetch for this branch
//  mispredict     out  1         registered; 1 cycle after upd_valid with wrong prediction
//  br_count       out  32        resolved-branch count (BP_PERF_CNT_EN only; else 0)
//  mp_count       out  32        mispredict count (BP_PERF_CNT_EN only; else 0)
// BEHAVIOUR
//  - State: PHT[2**IDX_BITS] of 2-bit counters; ghr[GHR_BITS-1:0]; mispredict flop.
//  - Index: pred_idx = pred_pc[IDX_BITS+1:2] ^ zero-extend(ghr) to IDX_BITS.
//  - Lookup: pred_taken = pred_valid & PHT[pred_idx][1]. pred_valid=0 -> pred_taken=0; pred_idx still driven.
//  - Counter FSM: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11).
//      upd_br_en=1: +1, saturates at 11.  upd_br_en=0: -1, saturates at 00.
//  - On upd_valid, at the next edge:
//      PHT[upd_idx] updated;
//      ghr <= {ghr[GHR_BITS-2:0], upd_br_en} (GHR_BITS=1: ghr <= upd_br_en);
//      mispredict <= (upd_br_en != upd_pred_taken).
//  - Without upd_valid: mispredict <= 0; PHT and ghr hold. mispredict is never asserted two cycles running
//    from a single pulse.
//  - Latency: lookup 0 cycles; training visible to lookups 1 cycle after upd_valid; mispredict 1 cycle after upd_valid.
//  - Same-cycle lookup and update of the same entry, or lookup during a GHR change:
//    lookup uses pre-update PHT and ghr (read-before-write).
//  - Stalls: block does no de-duplication. Upstream must pulse upd_valid exactly once per branch;
//    a held upd_valid trains once per cycle.
//  - Reset (any cycle, incl. mid-update): all PHT entries <= CTR_INIT, ghr <= 0, mispredict <= 0,
//    perf counters <= 0. upd_valid in the rst cycle is ignored.
//  - Arithmetic: counters saturate and never wrap. Index XOR truncates to IDX_BITS.
// CONFIGURATION
//  BP_PERF_CNT_EN defined:
//   - br_count increments on each accepted upd_valid.
//   - mp_count increments whenever mispredict is set.
//   - Both are 32-bit, saturate at 32'hFFFF_FFFF and reset to 0.
//  BP_PERF_CNT_EN undefined: no counter flops; br_count = mp_count = 32'h0. Ports remain for a stable interface.
// TESTING
//  T1 reset, pred_valid=1, pred_pc=32'h60 -> pred_idx=6'h18, pred_taken=0 (CTR_INIT=01).
//  T2 upd_valid idx=6'h18 br_en=1 pred_taken=0
//     -> next cycle mispredict=1, PHT[18]=10, ghr=6'h01; pc 32'h60 now maps to idx 6'h19, pred_taken=0.
//  T3 four taken updates to one idx -> counter 00..11 then holds 11; four not-taken -> 00 and holds;
//     pred_taken tracks ctr[1] each cycle.
//  T4 lookup and update same idx same cycle (ctr 01, br_en=1)
//     -> pred_taken=0 that cycle, 1 on the next lookup with unchanged GHR.
//  T5 rst asserted in the same cycle as upd_valid with a wrong prediction -> mispredict=0,
//     PHT[idx]=CTR_INIT, ghr=0 next cycle.
//  T6 BP_PERF_CNT_EN: 10 updates, 3 wrong -> br_count=10, mp_count=3; undefined: both read 0.

Source files
------------

// File: rtl/gshare_predictor_if.sv
// Fetch/EX-side bundle for the gshare direction predictor.
// master: pipeline (fetch request + EX resolve); slave: the predictor.
interface gshare_predictor_if #(
  parameter int IDX_BITS = 6
);
  logic                pred_valid;
  logic [31:0]         pred_pc;
  logic                pred_taken;
  logic [IDX_BITS-1:0] pred_idx;
  logic                upd_valid;
  logic [IDX_BITS-1:0] upd_idx;
  logic                upd_br_en;
  logic                upd_pred_taken;
  logic                mispredict;
  logic [31:0]         br_count;
  logic [31:0]         mp_count;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_idx, upd_br_en, upd_pred_taken,
    input  pred_taken, pred_idx, mispredict, br_count, mp_count
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_idx, upd_br_en, upd_pred_taken,
    output pred_taken, pred_idx, mispredict, br_count, mp_count
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare predictor: PHT of 2-bit saturating counters indexed by PC^GHR, trained from EX.
// Optional BP_PERF_CNT_EN adds saturating resolved-branch / mispredict counters.

// One PHT entry: 2-bit saturating direction counter.
module gshare_ctr #(
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_en,
  input  logic       br_en,
  output logic [1:0] ctr
);
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_t;

  ctr_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= ctr_t'(CTR_INIT);
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (upd_en) begin
      case (state)
        SNT:     state_nxt = br_en ? WNT : SNT;
        WNT:     state_nxt = br_en ? WT  : SNT;
        WT:      state_nxt = br_en ? ST  : WNT;
        ST:      state_nxt = br_en ? ST  : WT;
        default: state_nxt = state;
      endcase
    end
  end

  assign ctr = state;
endmodule

module gshare_predictor #(
  parameter int         IDX_BITS = 6,
  parameter int         GHR_BITS = 6,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic               clk,
  input  logic               rst,
  gshare_predictor_if.slave  bp
);
  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0][1:0] pht;
  logic [ENTRIES-1:0]      upd_sel;
  logic [GHR_BITS-1:0]     ghr, ghr_nxt;
  logic [IDX_BITS-1:0]     pred_idx;
  logic                    mispredict_q;
  logic                    mp_set;

  // Word-aligned PC bits hashed with history; upper PC bits and byte offset unused.
  assign pred_idx      = bp.pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
  assign bp.pred_idx   = pred_idx;
  assign bp.pred_taken = bp.pred_valid & pht[pred_idx][1];

  logic unused_pc;
  assign unused_pc = ^{bp.pred_pc[31:IDX_BITS+2], bp.pred_pc[1:0]};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_pht
    assign upd_sel[i] = bp.upd_valid & (bp.upd_idx == IDX_BITS'(i));
    gshare_ctr #(.CTR_INIT(CTR_INIT)) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .upd_en (upd_sel[i]),
      .br_en  (bp.upd_br_en),
      .ctr    (pht[i])
    );
  end

  if (GHR_BITS == 1) begin : g_ghr1
    assign ghr_nxt = bp.upd_br_en;
  end else begin : g_ghrn
    assign ghr_nxt = {ghr[GHR_BITS-2:0], bp.upd_br_en};
  end

  assign mp_set = bp.upd_valid & (bp.upd_br_en != bp.upd_pred_taken);

  // Lookups read the registered PHT/ghr, so a same-cycle update is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr          <= '0;
      mispredict_q <= 1'b0;
    end else begin
      if (bp.upd_valid) ghr <= ghr_nxt;
      mispredict_q <= mp_set;
    end
  end

  assign bp.mispredict = mispredict_q;

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (bp.upd_valid && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_q <= br_cnt_q + 32'd1;
      if (mp_set && (mp_cnt_q != 32'hFFFF_FFFF))       mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign bp.br_count = br_cnt_q;
  assign bp.mp_count = mp_cnt_q;
`else
  assign bp.br_count = 32'h0;
  assign bp.mp_count = 32'h0;
`endif
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor (IDX_BITS=6, GHR_BITS=6, CTR_INIT=01).
module tb_gshare_predictor;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  gshare_predictor_if #(.IDX_BITS(6)) bp ();

  gshare_predictor #(.IDX_BITS(6), .GHR_BITS(6), .CTR_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bp.upd_valid = 1'b0; bp.upd_idx = '0; bp.upd_br_en = 1'b0; bp.upd_pred_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); bp.pred_valid = 1'b1; bp.pred_pc = 32'h0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bp.pred_pc = 32'h60; #1;
    n_chk++; if (bp.pred_idx !== 6'h18) begin n_fail++; $display("FAIL reset_idx got %h exp 18", bp.pred_idx); end
    n_chk++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got %b exp 0", bp.pred_taken); end
    n_chk++; if (bp.mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mp got %b exp 0", bp.mispredict); end
    n_chk++; if (bp.br_count !== 32'h0) begin n_fail++; $display("FAIL reset_brcnt got %h exp 0", bp.br_count); end
    n_chk++; if (bp.mp_count !== 32'h0) begin n_fail++; $display("FAIL reset_mpcnt got %h exp 0", bp.mp_count); end
  endtask

  task automatic test_train();
    do_reset();
    bp.pred_pc = 32'h60;
    bp.upd_valid = 1'b1; bp.upd_idx = 6'h18; bp.upd_br_en = 1'b1; bp.upd_pred_taken = 1'b0;
    cyc(); idle(); #1;
    n_chk++; if (bp.mispredict !== 1'b1) begin n_fail++; $display("FAIL train_mp got %b exp 1", bp.mispredict); end
    bp.pred_pc = 32'h60; #1;
    n_chk++; if (bp.pred_idx !== 6'h19) begin n_fail++; $display("FAIL train_idx got %h exp 19", bp.pred_idx); end
    n_chk++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL train_taken19 got %b exp 0", bp.pred_taken); end
    bp.pred_pc = 32'h64; #1;
    n_chk++; if (bp.pred_idx !== 6'h18) begin n_fail++; $display("FAIL train_idx18 got %h exp 18", bp.pred_idx); end
    n_chk++; if (bp.pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_taken18 got %b exp 1", bp.pred_taken); end
    cyc();
    n_chk++; if (bp.mispredict !== 1'b0) begin n_fail++; $display("FAIL train_mp_pulse got %b exp 0", bp.mispredict); end
  endtask

  // Held upd_valid on entry 5: four taken then four not-taken, one training per cycle.
  task automatic test_saturate();
    logic [7:0] br = 8'b0000_1111;
    logic [7:0] et = 8'b0001_1111;
    logic [5:0] eg [8];
    eg = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1E, 6'h3C, 6'h38, 6'h30};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bp.upd_valid = 1'b1; bp.upd_idx = 6'h05; bp.upd_br_en = br[k]; bp.upd_pred_taken = 1'b0;
      cyc();
      n_chk++; if (bp.mispredict !== br[k]) begin n_fail++; $display("FAIL sat_mp[%0d] got %b exp %b", k, bp.mispredict, br[k]); end
      bp.pred_pc = 32'h0; #1;
      n_chk++; if (bp.pred_idx !== eg[k]) begin n_fail++; $display("FAIL sat_ghr[%0d] got %h exp %h", k, bp.pred_idx, eg[k]); end
      bp.pred_pc = {24'h0, 6'h05 ^ eg[k], 2'b00}; #1;
      n_chk++; if (bp.pred_taken !== et[k]) begin n_fail++; $display("FAIL sat_taken[%0d] got %b exp %b", k, bp.pred_taken, et[k]); end
      if (k == 3) begin
        bp.pred_valid = 1'b0; #1;
        n_chk++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL novalid_taken got %b exp 0", bp.pred_taken); end
        n_chk++; if (bp.pred_idx !== 6'h05) begin n_fail++; $display("FAIL novalid_idx got %h exp 05", bp.pred_idx); end
        bp.pred_valid = 1'b1;
      end
    end
    idle();
  endtask

  task automatic test_same_cycle();
    do_reset();
    bp.pred_pc = 32'h40;
    bp.upd_valid = 1'b1; bp.upd_idx = 6'h10; bp.upd_br_en = 1'b1; bp.upd_pred_taken = 1'b0; #1;
    n_chk++; if (bp.pred_idx !== 6'h10) begin n_fail++; $display("FAIL rbw_idx got %h exp 10", bp.pred_idx); end
    n_chk++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rbw_taken_old got %b exp 0", bp.pred_taken); end
    cyc(); idle();
    n_chk++; if (bp.mispredict !== 1'b1) begin n_fail++; $display("FAIL rbw_mp got %b exp 1", bp.mispredict); end
    bp.pred_pc = 32'h44; #1;
    n_chk++; if (bp.pred_idx !== 6'h10) begin n_fail++; $display("FAIL rbw_idx2 got %h exp 10", bp.pred_idx); end
    n_chk++; if (bp.pred_taken !== 1'b1) begin n_fail++; $display("FAIL rbw_taken_new got %b exp 1", bp.pred_taken); end
  endtask

  task automatic test_reset_mid_update();
    do_reset();
    bp.upd_valid = 1'b1; bp.upd_idx = 6'h18; bp.upd_br_en = 1'b1; bp.upd_pred_taken = 1'b0;
    cyc(); cyc();
    rst = 1'b1; bp.upd_br_en = 1'b0; bp.upd_pred_taken = 1'b1;
    cyc();
    rst = 1'b0; idle(); #1;
    n_chk++; if (bp.mispredict !== 1'b0) begin n_fail++; $display("FAIL rstupd_mp got %b exp 0", bp.mispredict); end
    bp.pred_pc = 32'h60; #1;
    n_chk++; if (bp.pred_idx !== 6'h18) begin n_fail++; $display("FAIL rstupd_ghr got %h exp 18", bp.pred_idx); end
    n_chk++; if (bp.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rstupd_taken got %b exp 0", bp.pred_taken); end
  endtask

  // Ten back-to-back resolutions, three of them mispredicted.
  task automatic test_back_to_back();
    logic [9:0] br   = 10'b10_1001_1101;
    logic [9:0] flip = 10'b00_1001_0001;
    logic [5:0] ix;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ix = 6'(k);
      bp.upd_valid = 1'b1; bp.upd_idx = ix; bp.upd_br_en = br[k]; bp.upd_pred_taken = br[k] ^ flip[k];
      cyc();
      n_chk++; if (bp.mispredict !== flip[k]) begin n_fail++; $display("FAIL b2b_mp[%0d] got %b exp %b", k, bp.mispredict, flip[k]); end
    end
    idle(); cyc();
    n_chk++; if (bp.mispredict !== 1'b0) begin n_fail++; $display("FAIL b2b_mp_end got %b exp 0", bp.mispredict); end
`ifdef BP_PERF_CNT_EN
    n_chk++; if (bp.br_count !== 32'd10) begin n_fail++; $display("FAIL perf_br got %0d exp 10", bp.br_count); end
    n_chk++; if (bp.mp_count !== 32'd3) begin n_fail++; $display("FAIL perf_mp got %0d exp 3", bp.mp_count); end
`else
    n_chk++; if (bp.br_count !== 32'd0) begin n_fail++; $display("FAIL perf_br got %0d exp 0", bp.br_count); end
    n_chk++; if (bp.mp_count !== 32'd0) begin n_fail++; $display("FAIL perf_mp got %0d exp 0", bp.mp_count); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bp.pred_valid = 1'b0; bp.pred_pc = 32'h0; idle();
    test_reset();
    test_train();
    test_saturate();
    test_same_cycle();
    test_reset_mid_update();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
